// File: rtl/user_login.sv
`default_nettype none
// ============================================================================
//  Module   : user_login
//  Purpose  : Password-entry stage following the user-select stage. The guest
//             path grants guest mode at once. The password path collects
//             PW_LEN 4-bit digits, compares them with a stored code, counts
//             failed attempts and imposes a timed lockout after MAX_TRIES
//             consecutive failures.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             pw_mode          - 1 = password required, 0 = guest
//             digit[3:0]       - digit value, qualified by digit_valid
//             digit_valid      - single-cycle enter strobe
//             access_granted   - sticky, correct password entered
//             guest_mode       - sticky, guest path taken
//             login_fail       - one-cycle pulse per wrong attempt
//             locked_out       - high for LOCK_CYCLES cycles after lockout
//             digit_count[2:0] - digits accepted in current attempt
//             tries_left[2:0]  - attempts remaining before lockout
//  Revision : 1.0 - initial release
// ============================================================================
module user_login #(
    parameter int                    PW_LEN      = 4,
    parameter logic [4*PW_LEN-1:0]   PASSWORD    = 16'h1234,
    parameter int                    MAX_TRIES   = 3,
    parameter int unsigned           LOCK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pw_mode,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    output logic       access_granted,
    output logic       guest_mode,
    output logic       login_fail,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [2:0] tries_left
);

    // digit_count is 3 bits wide, so with PW_LEN=8 it wraps to 0 on the final
    // digit; the last-digit test therefore looks at the count before the
    // increment rather than after it.
    localparam logic [2:0]  C_LAST_IDX  = 3'(PW_LEN - 1);
    localparam logic [2:0]  C_MAX_TRIES = 3'(MAX_TRIES);
    localparam logic [31:0] C_LOCK_LOAD = 32'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GUEST = 3'd1,
        S_ENTER = 3'd2,
        S_CHECK = 3'd3,
        S_FAIL  = 3'd4,
        S_LOCK  = 3'd5,
        S_GRANT = 3'd6
    } state_t;

    state_t                r_state;
    logic [4*PW_LEN-1:0]   r_buffer;
    logic [31:0]           r_lock_cnt;
    logic [4*PW_LEN-1:0]   w_next_buf;

    // Shift the new digit in at the LS nibble so the first digit entered ends
    // up in the MS nibble, matching the layout of PASSWORD.
    generate
        if (PW_LEN == 1) begin : g_shift_single
            assign w_next_buf = digit;
        end else begin : g_shift_multi
            assign w_next_buf = {r_buffer[4*PW_LEN-5:0], digit};
        end
    endgenerate

    // All outputs are registered and updated on the same edge as the state
    // transition, so each one reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_buffer       <= '0;
            r_lock_cnt     <= '0;
            access_granted <= 1'b0;
            guest_mode     <= 1'b0;
            login_fail     <= 1'b0;
            locked_out     <= 1'b0;
            digit_count    <= 3'd0;
            tries_left     <= C_MAX_TRIES;
        end else begin
            login_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pw_mode) begin
                        r_state <= S_ENTER;
                    end else begin
                        r_state    <= S_GUEST;
                        guest_mode <= 1'b1;
                    end
                end

                S_GUEST: begin
                end

                S_ENTER: begin
                    if (digit_valid) begin
                        r_buffer    <= w_next_buf;
                        digit_count <= digit_count + 3'd1;
                        if (digit_count == C_LAST_IDX) begin
                            r_state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (r_buffer == PASSWORD) begin
                        r_state        <= S_GRANT;
                        access_granted <= 1'b1;
                    end else begin
                        tries_left <= tries_left - 3'd1;
                        login_fail <= 1'b1;
                        if (tries_left == 3'd1) begin
                            // Last try used up: start the lockout directly.
                            r_state     <= S_LOCK;
                            locked_out  <= 1'b1;
                            r_buffer    <= '0;
                            digit_count <= 3'd0;
                            r_lock_cnt  <= C_LOCK_LOAD;
                        end else begin
                            r_state <= S_FAIL;
                        end
                    end
                end

                S_FAIL: begin
                    r_buffer    <= '0;
                    digit_count <= 3'd0;
                    r_state     <= S_ENTER;
                end

                S_LOCK: begin
                    // Counter was loaded with LOCK_CYCLES-1 on entry, so the
                    // cycle that reads zero is the last of LOCK_CYCLES cycles.
                    if (r_lock_cnt == 32'd0) begin
                        locked_out <= 1'b0;
                        tries_left <= C_MAX_TRIES;
                        r_state    <= S_ENTER;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 32'd1;
                    end
                end

                S_GRANT: begin
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_user_login.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_login
//  Purpose  : Scoreboard bench for user_login. The driver enters codes,
//             predicts each attempt's outcome from the login rules and queues
//             it; an independent monitor pops and compares whenever the DUT
//             reports a grant or a failed attempt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_user_login;

    localparam int          PW_LEN      = 4;
    localparam logic [15:0] PASSWORD    = 16'h1234;
    localparam int          MAX_TRIES   = 3;
    localparam int          LOCK_CYCLES = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pw_mode = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       access_granted, guest_mode, login_fail, locked_out;
    logic [2:0] digit_count, tries_left;

    user_login #(
        .PW_LEN      (PW_LEN),
        .PASSWORD    (PASSWORD),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pw_mode        (pw_mode),
        .digit          (digit),
        .digit_valid    (digit_valid),
        .access_granted (access_granted),
        .guest_mode     (guest_mode),
        .login_fail     (login_fail),
        .locked_out     (locked_out),
        .digit_count    (digit_count),
        .tries_left     (tries_left)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        bit is_grant;
        int edge_at;
        int tries;
        bit lock;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    int m_tries;
    int m_count;
    int m_code;
    bit m_granted;

    task automatic check(input string name, input longint actual, input longint expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic strobe(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        digit       = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset(input bit mode);
        rst         = 1'b1;
        pw_mode     = mode;
        digit_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pending responses before reset", sb_q.size(), 0);
        sb_q.delete();
        m_tries   = MAX_TRIES;
        m_granted = 1'b0;
        check("reset access_granted", access_granted, 0);
        check("reset guest_mode", guest_mode, 0);
        check("reset login_fail", login_fail, 0);
        check("reset locked_out", locked_out, 0);
        check("reset digit_count", digit_count, 0);
        check("reset tries_left", tries_left, MAX_TRIES);
        rst = 1'b0;
    endtask

    task automatic attempt(input logic [15:0] code, input bit gaps, input bit toggle_mode);
        exp_t e;
        logic [3:0] d;
        int guard;
        m_code  = 0;
        m_count = 0;
        for (int i = 0; i < PW_LEN; i++) begin
            d = code[4*(PW_LEN-1-i) +: 4];
            strobe(d);
            m_count++;
            m_code = m_code * 16 + int'(d);
            check("digit_count step", digit_count, m_count);
            if (toggle_mode && i == 0) begin
                pw_mode = 1'b0;
                repeat (3) @(negedge clk);
                check("guest_mode after pw_mode toggle", guest_mode, 0);
                check("digit_count after pw_mode toggle", digit_count, m_count);
            end
            if (gaps && i < PW_LEN - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        pw_mode   = 1'b1;
        e.edge_at = edge_cnt + 1;
        if (m_code == int'(PASSWORD)) begin
            e.is_grant = 1'b1;
            e.tries    = m_tries;
            e.lock     = 1'b0;
            m_granted  = 1'b1;
        end else begin
            m_tries    = m_tries - 1;
            e.is_grant = 1'b0;
            e.tries    = m_tries;
            e.lock     = (m_tries == 0);
        end
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        if (!e.is_grant && !e.lock) check("digit_count cleared after fail", digit_count, 0);
        if (e.lock) begin
            guard = 0;
            while (locked_out && guard < 200) begin
                if ($urandom_range(0, 1) == 1) begin
                    strobe(4'($urandom_range(0, 15)));
                    check("digit_count during lockout", digit_count, 0);
                end else begin
                    @(negedge clk);
                end
                guard++;
            end
            check("lockout released", locked_out, 0);
            m_tries = MAX_TRIES;
        end
    endtask

    function automatic logic [15:0] wrong_code();
        logic [15:0] c;
        c = 16'($urandom_range(0, 65535));
        if (c == PASSWORD) c = c ^ 16'h0001;
        return c;
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   prev_grant = 1'b0;
    bit   fail_chk   = 1'b0;
    int   lock_run   = 0;

    always @(negedge clk) begin
        if (rst) begin
            lock_run = 0;
            fail_chk = 1'b0;
        end else begin
            if (fail_chk) begin
                check("login_fail one-cycle pulse", login_fail, 0);
                fail_chk = 1'b0;
            end
            if ((access_granted && !prev_grant) || login_fail) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected response: access_granted=%0d login_fail=%0d, none expected (t=%0t)",
                             access_granted, login_fail, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("response kind (access_granted)", access_granted, mon_e.is_grant);
                    check("response kind (login_fail)", login_fail, !mon_e.is_grant);
                    check("response latency edge", edge_cnt, mon_e.edge_at);
                    check("tries_left at response", tries_left, mon_e.tries);
                    check("locked_out at response", locked_out, mon_e.lock);
                    if (!mon_e.is_grant) fail_chk = 1'b1;
                end
            end
            if (locked_out) begin
                lock_run++;
            end else if (lock_run > 0) begin
                check("lockout length", lock_run, LOCK_CYCLES);
                check("tries_left after lockout", tries_left, MAX_TRIES);
                lock_run = 0;
            end
        end
        prev_grant = access_granted;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_att;
        @(negedge clk);

        // Guest path: digits are ignored and guest mode is sticky.
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        check("guest_mode two cycles after release", guest_mode, 1);
        strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
        pw_mode = 1'b1;
        repeat (3) @(negedge clk);
        check("guest access_granted", access_granted, 0);
        check("guest digit_count", digit_count, 0);
        check("guest_mode sticky", guest_mode, 1);

        // Correct code with idle gaps; further digits are ignored once granted.
        do_reset(1'b1);
        @(negedge clk);
        attempt(PASSWORD, 1'b1, 1'b0);
        strobe(4'h7);
        repeat (2) @(negedge clk);
        check("granted access_granted sticky", access_granted, 1);
        check("granted guest_mode", guest_mode, 0);
        check("granted digit_count frozen", digit_count, PW_LEN);

        // One wrong code, then the right one.
        do_reset(1'b1);
        @(negedge clk);
        attempt(16'h1235, 1'b0, 1'b0);
        attempt(PASSWORD, 1'b1, 1'b0);

        // Lockout after MAX_TRIES wrong codes, then grant.
        do_reset(1'b1);
        @(negedge clk);
        for (int i = 0; i < MAX_TRIES; i++) attempt(wrong_code(), 1'b1, 1'b0);
        check("tries_left restored", tries_left, MAX_TRIES);
        attempt(PASSWORD, 1'b0, 1'b0);

        // Reset mid-entry discards the partial code.
        do_reset(1'b1);
        @(negedge clk);
        strobe(4'h1);
        check("partial digit_count 1", digit_count, 1);
        strobe(4'h2);
        check("partial digit_count 2", digit_count, 2);
        do_reset(1'b1);
        @(negedge clk);
        attempt(PASSWORD, 1'b0, 1'b0);

        // pw_mode toggled during entry has no effect.
        do_reset(1'b1);
        @(negedge clk);
        attempt(PASSWORD, 1'b0, 1'b1);

        // Randomized sessions: mix of wrong and right codes until granted.
        for (int s = 0; s < 8; s++) begin
            do_reset(1'b1);
            @(negedge clk);
            n_att = 0;
            while (!m_granted && n_att < 8) begin
                if ($urandom_range(0, 3) == 0) attempt(PASSWORD, 1'b1, 1'b0);
                else attempt(wrong_code(), 1'b1, 1'b0);
                n_att++;
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
